pc_field_unit: RTL and testbench
================================

Name: pc_field_unit

Overview:
- Parametrised program-counter and memory-field unit for the PDP-8/e-style CPU. Successor to the fixed 12-bit PC.
- Holds the PC plus the extended-memory field registers: instruction field (IF), instruction buffer (IB), data field (DF) and save field (SF).
- Executes one-cycle PC commands issued by the major-state controller: increment, skip, direct/indirect jump, JMS, interrupt entry.
- Implements CIF-deferred field transfer and interrupt inhibit.

Parameters:
- WIDTH, 12, PC/address width.
- PAGE_BITS, 7, in-page offset width; page = 2^PAGE_BITS words.
- FIELD_BITS, 3, width of IF/IB/DF.
- RESET_PC, 12'o0200, PC value after reset.
- INT_VECTOR, 12'o0001, PC loaded on interrupt entry.
- HIST_DEPTH, 8, jump-history entries (power of 2, ≥2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command strobe
- cmd  in  3  0 NOP, 1 INC, 2 SKIP, 3 JMP_DIR, 4 LOAD, 5 JMS, 6 INTR, 7 reserved (acts as NOP)
- page_bit  in  1  JMP_DIR page select (0 = page zero, 1 = current page)
- offset  in  PAGE_BITS  JMP_DIR in-page address
- ld_addr  in  WIDTH  target for LOAD/JMS
- field_wr  in  1  field-op strobe
- field_op  in  2  0 CDF, 1 CIF, 2 CDF+CIF, 3 RMF
- field_val  in  FIELD_BITS  field number for CDF/CIF
- pc  out  WIDTH  program counter
- ifld  out  FIELD_BITS  instruction field
- ib  out  FIELD_BITS  instruction buffer
- dfld  out  FIELD_BITS  data field
- sf  out  2*FIELD_BITS  save field, {IF,DF}
- int_inhibit  out  1  interrupts must not be granted
- hist_idx  in  log2(HIST_DEPTH)  history read index (0 = newest)
- hist_data  out  FIELD_BITS+WIDTH  {field, pc} history entry
- hist_count  out  log2(HIST_DEPTH)+1  valid history entries

Behaviour:
- All state updates on posedge clk. Outputs are registered; a command is visible on pc the cycle after cmd_valid.
- Reset values: pc=RESET_PC; ifld, ib, dfld, sf = 0; int_inhibit=0; hist_count=0. Reset mid-command discards the command.
- Command results (all arithmetic mod 2^WIDTH):
  - INC: pc+1. 7777 wraps to 0000.
  - SKIP: pc+2. 7776→0000, 7777→0001.
  - JMP_DIR: page_bit=0 → {0, offset}; page_bit=1 → {pc[WIDTH-1:PAGE_BITS], offset}. Page is taken from the pc value before the update.
  - LOAD: pc=ld_addr. Used for JMP indirect and panel sync.
  - JMS: pc=ld_addr+1.
  - INTR: pc=INT_VECTOR; sf={ifld,dfld}; ifld, ib, dfld = 0; int_inhibit=0.
  - NOP / 7: pc held.
- Field transfer: JMP_DIR, LOAD and JMS also set ifld=ib and clear int_inhibit.
- Field ops (field_wr):
  - CDF: dfld=field_val.
  - CIF: ib=field_val, int_inhibit=1.
  - CDF+CIF: both of the above.
  - RMF: ib=sf[IF part], dfld=sf[DF part], int_inhibit=1.
- Simultaneous events:
  - Field op with a jump: ifld takes the OLD ib; ib/dfld/int_inhibit take the field-op result.
  - Field op with INTR: INTR wins and the field op is dropped.
  - Field op with INC/SKIP/NOP: both apply.
- cmd_valid=0: no PC change. field_wr is independent of cmd_valid.

Optional Feature:
- Macro PC_HIST_EN.
- When defined: an HIST_DEPTH-entry circular buffer records {ifld, pc} (values before update) on every JMP_DIR, LOAD, JMS and INTR.
  - hist_data is combinational from hist_idx; index 0 is the newest entry.
  - hist_count saturates at HIST_DEPTH. Oldest entries are overwritten.
  - An index ≥ hist_count returns 0.
  - Reset clears hist_count; buffer contents are don't-care.
- When undefined: no storage is built; hist_data=0 and hist_count=0 constantly.

Test Plan:
- Reset → pc=0200, ifld=ib=dfld=0, sf=00, int_inhibit=0.
- pc=7777, INC → 0000. pc=7776, SKIP → 0000. pc=7777, SKIP → 0001.
- pc=4321: JMP_DIR page_bit=1 offset=055 → 4255. Then JMP_DIR page_bit=0 offset=055 → 0055.
- CIF field_val=3 → ib=3, ifld=0, int_inhibit=1. Then JMS ld_addr=0500 → pc=0501, ifld=3, int_inhibit=0.
- ifld=3, dfld=5, INTR with a simultaneous CDF 7 → pc=0001, sf=35, dfld=0. Then RMF → ib=3, dfld=5, int_inhibit=1.
- PC_HIST_EN, 10 jumps to distinct targets → hist_count=8, hist_idx=0 returns the pc before the 10th jump, hist_idx=7 returns the pc before the 3rd.

Source files
------------

// File: rtl/pc_field_unit.sv
// Program counter plus IF/IB/DF/SF field registers for a PDP-8/e style CPU.
// Optional jump-history buffer is built only when PC_HIST_EN is defined.
module pc_field_unit #(
    parameter int                        WIDTH      = 12,
    parameter int                        PAGE_BITS  = 7,
    parameter int                        FIELD_BITS = 3,
    parameter logic [WIDTH-1:0]          RESET_PC   = 12'o0200,
    parameter logic [WIDTH-1:0]          INT_VECTOR = 12'o0001,
    parameter int                        HIST_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cmd_valid,
    input  logic [2:0]                        cmd,
    input  logic                              page_bit,
    input  logic [PAGE_BITS-1:0]              offset,
    input  logic [WIDTH-1:0]                  ld_addr,
    input  logic                              field_wr,
    input  logic [1:0]                        field_op,
    input  logic [FIELD_BITS-1:0]             field_val,
    output logic [WIDTH-1:0]                  pc,
    output logic [FIELD_BITS-1:0]             ifld,
    output logic [FIELD_BITS-1:0]             ib,
    output logic [FIELD_BITS-1:0]             dfld,
    output logic [2*FIELD_BITS-1:0]           sf,
    output logic                              int_inhibit,
    input  logic [$clog2(HIST_DEPTH)-1:0]     hist_idx,
    output logic [FIELD_BITS+WIDTH-1:0]       hist_data,
    output logic [$clog2(HIST_DEPTH):0]       hist_count
);
    localparam int HIST_AW = $clog2(HIST_DEPTH);

    localparam logic [2:0] CMD_INC  = 3'd1;
    localparam logic [2:0] CMD_SKIP = 3'd2;
    localparam logic [2:0] CMD_JMPD = 3'd3;
    localparam logic [2:0] CMD_LOAD = 3'd4;
    localparam logic [2:0] CMD_JMS  = 3'd5;
    localparam logic [2:0] CMD_INTR = 3'd6;

    localparam logic [1:0] FOP_CDF  = 2'd0;
    localparam logic [1:0] FOP_CIF  = 2'd1;
    localparam logic [1:0] FOP_BOTH = 2'd2;
    localparam logic [1:0] FOP_RMF  = 2'd3;

    logic [WIDTH-1:0]        pc_q,   pc_d;
    logic [FIELD_BITS-1:0]   ifld_q, ifld_d;
    logic [FIELD_BITS-1:0]   ib_q,   ib_d;
    logic [FIELD_BITS-1:0]   dfld_q, dfld_d;
    logic [2*FIELD_BITS-1:0] sf_q,   sf_d;
    logic                    inh_q,  inh_d;
    logic                    is_jump;
    logic                    is_intr;

    assign is_jump = cmd_valid && (cmd == CMD_JMPD || cmd == CMD_LOAD || cmd == CMD_JMS);
    assign is_intr = cmd_valid && (cmd == CMD_INTR);

    always_comb begin
        pc_d   = pc_q;
        ifld_d = ifld_q;
        ib_d   = ib_q;
        dfld_d = dfld_q;
        sf_d   = sf_q;
        inh_d  = inh_q;

        if (cmd_valid) begin
            case (cmd)
                CMD_INC:  pc_d = pc_q + WIDTH'(1);
                CMD_SKIP: pc_d = pc_q + WIDTH'(2);
                CMD_JMPD: pc_d = page_bit ? {pc_q[WIDTH-1:PAGE_BITS], offset}
                                          : {{(WIDTH-PAGE_BITS){1'b0}}, offset};
                CMD_LOAD: pc_d = ld_addr;
                CMD_JMS:  pc_d = ld_addr + WIDTH'(1);
                CMD_INTR: pc_d = INT_VECTOR;
                default:  pc_d = pc_q;
            endcase
        end

        // Deferred field transfer: IF picks up the IB value held before any
        // field op in this same cycle rewrites IB.
        if (is_jump) begin
            ifld_d = ib_q;
            inh_d  = 1'b0;
        end

        if (is_intr) begin
            sf_d   = {ifld_q, dfld_q};
            ifld_d = '0;
            ib_d   = '0;
            dfld_d = '0;
            inh_d  = 1'b0;
        end else if (field_wr) begin
            case (field_op)
                FOP_CDF:  dfld_d = field_val;
                FOP_CIF: begin
                    ib_d  = field_val;
                    inh_d = 1'b1;
                end
                FOP_BOTH: begin
                    dfld_d = field_val;
                    ib_d   = field_val;
                    inh_d  = 1'b1;
                end
                FOP_RMF: begin
                    ib_d   = sf_q[2*FIELD_BITS-1:FIELD_BITS];
                    dfld_d = sf_q[FIELD_BITS-1:0];
                    inh_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            ifld_q <= '0;
            ib_q   <= '0;
            dfld_q <= '0;
            sf_q   <= '0;
            inh_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ifld_q <= ifld_d;
            ib_q   <= ib_d;
            dfld_q <= dfld_d;
            sf_q   <= sf_d;
            inh_q  <= inh_d;
        end
    end

    assign pc          = pc_q;
    assign ifld        = ifld_q;
    assign ib          = ib_q;
    assign dfld        = dfld_q;
    assign sf          = sf_q;
    assign int_inhibit = inh_q;

`ifdef PC_HIST_EN
    logic [FIELD_BITS+WIDTH-1:0] hist_mem [HIST_DEPTH];
    logic [HIST_AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [HIST_AW:0]            cnt_q,    cnt_d;
    logic [HIST_AW-1:0]          rd_ptr;
    logic                        hist_wr;

    assign hist_wr = is_jump || is_intr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (hist_wr) begin
            wr_ptr_d = wr_ptr_q + HIST_AW'(1);
            if (cnt_q != (HIST_AW+1)'(HIST_DEPTH))
                cnt_d = cnt_q + (HIST_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (hist_wr && !reset)
            hist_mem[wr_ptr_q] <= {ifld_q, pc_q};
    end

    // Newest entry sits one slot behind the write pointer.
    assign rd_ptr     = wr_ptr_q - HIST_AW'(1) - hist_idx;
    assign hist_data  = ({1'b0, hist_idx} < cnt_q) ? hist_mem[rd_ptr] : '0;
    assign hist_count = cnt_q;
`else
    logic unused_hist_idx;
    assign unused_hist_idx = ^hist_idx;
    assign hist_data       = '0;
    assign hist_count      = '0;
`endif

endmodule

// File: tb/tb_pc_field_unit.sv
// Directed bench for pc_field_unit: PC commands, field ops, interrupts, history.
module tb_pc_field_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic        page_bit;
    logic [6:0]  offset;
    logic [11:0] ld_addr;
    logic        field_wr;
    logic [1:0]  field_op;
    logic [2:0]  field_val;
    logic [11:0] pc;
    logic [2:0]  ifld, ib, dfld;
    logic [5:0]  sf;
    logic        int_inhibit;
    logic [2:0]  hist_idx;
    logic [14:0] hist_data;
    logic [3:0]  hist_count;

    int n_checks = 0;
    int n_fail   = 0;

    pc_field_unit dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .page_bit(page_bit), .offset(offset), .ld_addr(ld_addr),
        .field_wr(field_wr), .field_op(field_op), .field_val(field_val),
        .pc(pc), .ifld(ifld), .ib(ib), .dfld(dfld), .sf(sf),
        .int_inhibit(int_inhibit), .hist_idx(hist_idx),
        .hist_data(hist_data), .hist_count(hist_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
        end else begin
            $display("ok   %s = %0o", tag, got);
        end
    endtask

    // One clock with the given inputs applied, then inputs return idle.
    task automatic step(input logic v, input logic [2:0] c, input logic pb,
                        input logic [6:0] off, input logic [11:0] a,
                        input logic fw, input logic [1:0] fo, input logic [2:0] fv);
        cmd_valid = v;  cmd = c;  page_bit = pb;  offset = off;  ld_addr = a;
        field_wr = fw;  field_op = fo;  field_val = fv;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;  cmd = 3'd0;  field_wr = 1'b0;
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [11:0] a);
        step(1'b1, c, 1'b0, 7'o0, a, 1'b0, 2'd0, 3'd0);
    endtask

    task automatic do_fop(input logic [1:0] fo, input logic [2:0] fv);
        step(1'b0, 3'd0, 1'b0, 7'o0, 12'o0, 1'b1, fo, fv);
    endtask

    initial begin
        reset = 1'b1;  hist_idx = 3'd0;
        cmd_valid = 1'b0;  cmd = 3'd0;  page_bit = 1'b0;  offset = 7'o0;
        ld_addr = 12'o0;  field_wr = 1'b0;  field_op = 2'd0;  field_val = 3'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_pc",   32'(pc), 32'o0200);
        chk("rst_ifld", 32'(ifld), 32'o0);
        chk("rst_ib",   32'(ib), 32'o0);
        chk("rst_dfld", 32'(dfld), 32'o0);
        chk("rst_sf",   32'(sf), 32'o00);
        chk("rst_inh",  32'(int_inhibit), 32'd0);
        chk("rst_hcnt", 32'(hist_count), 32'd0);

        do_cmd(3'd4, 12'o7777);  do_cmd(3'd1, 12'o0);
        chk("inc_wrap", 32'(pc), 32'o0000);
        do_cmd(3'd4, 12'o7776);  do_cmd(3'd2, 12'o0);
        chk("skip_7776", 32'(pc), 32'o0000);
        do_cmd(3'd4, 12'o7777);  do_cmd(3'd2, 12'o0);
        chk("skip_7777", 32'(pc), 32'o0001);

        step(1'b0, 3'd1, 1'b0, 7'o0, 12'o0, 1'b0, 2'd0, 3'd0);
        chk("novalid_hold", 32'(pc), 32'o0001);
        do_cmd(3'd7, 12'o0);
        chk("rsvd_hold", 32'(pc), 32'o0001);
        do_cmd(3'd0, 12'o0);
        chk("nop_hold", 32'(pc), 32'o0001);

        do_cmd(3'd4, 12'o4321);
        step(1'b1, 3'd3, 1'b1, 7'o055, 12'o0, 1'b0, 2'd0, 3'd0);
        chk("jmp_curpage", 32'(pc), 32'o4255);
        step(1'b1, 3'd3, 1'b0, 7'o055, 12'o0, 1'b0, 2'd0, 3'd0);
        chk("jmp_page0", 32'(pc), 32'o0055);

        do_fop(2'd1, 3'd3);
        chk("cif_ib",   32'(ib), 32'o3);
        chk("cif_ifld", 32'(ifld), 32'o0);
        chk("cif_inh",  32'(int_inhibit), 32'd1);
        do_cmd(3'd5, 12'o0500);
        chk("jms_pc",   32'(pc), 32'o0501);
        chk("jms_ifld", 32'(ifld), 32'o3);
        chk("jms_inh",  32'(int_inhibit), 32'd0);

        step(1'b1, 3'd1, 1'b0, 7'o0, 12'o0, 1'b1, 2'd0, 3'd5);
        chk("inc_cdf_pc",   32'(pc), 32'o0502);
        chk("inc_cdf_dfld", 32'(dfld), 32'o5);

        step(1'b1, 3'd6, 1'b0, 7'o0, 12'o0, 1'b1, 2'd0, 3'd7);
        chk("intr_pc",   32'(pc), 32'o0001);
        chk("intr_sf",   32'(sf), 32'o35);
        chk("intr_dfld", 32'(dfld), 32'o0);
        chk("intr_ifld", 32'(ifld), 32'o0);
        chk("intr_inh",  32'(int_inhibit), 32'd0);

        do_fop(2'd3, 3'd0);
        chk("rmf_ib",   32'(ib), 32'o3);
        chk("rmf_dfld", 32'(dfld), 32'o5);
        chk("rmf_inh",  32'(int_inhibit), 32'd1);

        step(1'b1, 3'd4, 1'b0, 7'o0, 12'o1234, 1'b1, 2'd1, 3'd6);
        chk("ldcif_pc",   32'(pc), 32'o1234);
        chk("ldcif_ifld", 32'(ifld), 32'o3);
        chk("ldcif_ib",   32'(ib), 32'o6);
        chk("ldcif_inh",  32'(int_inhibit), 32'd1);

        reset = 1'b1;
        do_cmd(3'd4, 12'o7000);
        reset = 1'b0;
        chk("rstcmd_pc", 32'(pc), 32'o0200);
        chk("rstcmd_ib", 32'(ib), 32'o0);

        for (int i = 0; i < 10; i++) begin
            do_cmd(3'd4, 12'o1000 + 12'(i));
`ifdef PC_HIST_EN
            if (i == 1) begin
                hist_idx = 3'd2;  #1;
                chk("hist_beyond", 32'(hist_data), 32'd0);
                hist_idx = 3'd1;  #1;
                chk("hist_first", 32'(hist_data), 32'o0200);
            end
`endif
        end
`ifdef PC_HIST_EN
        chk("hist_count", 32'(hist_count), 32'd8);
        hist_idx = 3'd0;  #1;
        chk("hist_idx0", 32'(hist_data), 32'o1010);
        hist_idx = 3'd7;  #1;
        chk("hist_idx7", 32'(hist_data), 32'o1001);
`else
        chk("hist_count_off", 32'(hist_count), 32'd0);
        hist_idx = 3'd0;  #1;
        chk("hist_data_off", 32'(hist_data), 32'd0);
`endif
        chk("hist_final_pc", 32'(pc), 32'o1011);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
